// File: rtl/nibble_comp_seq_pkg.sv
// Shared types for the nibble-serial magnitude comparator sequencer.
package nibble_comp_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } cmp_state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_GT,
        RES_LT
    } cmp_res_t;

endpackage

// File: rtl/four_bit_comp.sv
// Existing 4-bit unsigned magnitude comparator: exactly one of G/L/E is high.
module four_bit_comp (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    output logic G,
    output logic L,
    output logic E
);

    logic [3:0] a_vec;
    logic [3:0] b_vec;

    assign a_vec = {a3, a2, a1, a0};
    assign b_vec = {b3, b2, b1, b0};

    assign G = (a_vec > b_vec);
    assign L = (a_vec < b_vec);
    assign E = (a_vec == b_vec);

endmodule

// File: rtl/nibble_comp_seq.sv
// Compares two WIDTH-bit words MSB nibble first through one shared four_bit_comp.
// Optional CMP_EARLY_EXIT_EN: finish on the first deciding nibble instead of a constant-time scan.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// CMP   | feeding nibble idx to the comparator, latching the first decision
// DONE  | presenting the one-hot result until out_ready
module nibble_comp_seq
    import nibble_comp_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    cmp_state_t             state_q, state_d;
    cmp_res_t               res_q, res_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NIBBLE_W-1:0]    nib_a;
    logic [NIBBLE_W-1:0]    nib_b;
    logic                   cmp_g;
    logic                   cmp_l;
    logic                   cmp_e;
    logic                   decide;

    assign nib_a = NIBBLE_W'(a_q >> (idx_q * NIBBLE_W));
    assign nib_b = NIBBLE_W'(b_q >> (idx_q * NIBBLE_W));

    four_bit_comp u_cmp (
        .a0 (nib_a[0]),
        .a1 (nib_a[1]),
        .a2 (nib_a[2]),
        .a3 (nib_a[3]),
        .b0 (nib_b[0]),
        .b1 (nib_b[1]),
        .b2 (nib_b[2]),
        .b3 (nib_b[3]),
        .G  (cmp_g),
        .L  (cmp_l),
        .E  (cmp_e)
    );

    // Only the first deciding nibble counts; lower nibbles never override it.
    assign decide = (res_q == RES_NONE) && (cmp_g || cmp_l);

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        gt        = 1'b0;
        lt        = 1'b0;
        eq        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_W'(NIB - 1);
                    res_d   = RES_NONE;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (decide) begin
                    res_d = cmp_g ? RES_GT : RES_LT;
                end
`ifdef CMP_EARLY_EXIT_EN
                if ((idx_q == '0) || decide) begin
`else
                if (idx_q == '0) begin
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                gt        = (res_q == RES_GT);
                lt        = (res_q == RES_LT);
                eq        = (res_q == RES_NONE);
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= RES_NONE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

`ifndef SYNTHESIS
    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == CMP) |-> ((cmp_g + cmp_l + cmp_e) == 2'd1));
`endif

endmodule

// File: tb/tb_nibble_comp_seq.sv
// Scoreboard bench for nibble_comp_seq: accept monitor pushes model results, output monitor pops.
module tb_nibble_comp_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           t0;
        int           lat;
    } txn_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic         gt;
    logic         lt;
    logic         eq;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    txn_t sb[$];
    bit   b2b_mode     = 1'b0;
    bit   prev_acc_b2b = 1'b0;
    int   prev_t0      = 0;
    int   prev_lat     = 0;
    bit   held         = 1'b0;
    logic [2:0] held_res = 3'b000;

    nibble_comp_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: cycles from accept to out_valid, from the position of the first differing nibble.
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int k_first;
        k_first = NIB;
        for (int k = NIB; k >= 1; k--) begin
            if (((x >> (4 * (NIB - k))) & W'(15)) != ((y >> (4 * (NIB - k))) & W'(15)))
                k_first = k;
        end
        return EARLY ? k_first : NIB;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (out_valid) begin
                check(in_ready == 1'b0, "in_ready_busy", in_ready, 0);
                check((gt + lt + eq) == 2'd1, "result_onehot", {gt, lt, eq}, 0);
                if (held) begin
                    check({gt, lt, eq} == held_res, "result_stable", {gt, lt, eq}, held_res);
                end else if (sb.size() == 0) begin
                    check(1'b0, "unexpected_result", {gt, lt, eq}, 0);
                end else begin
                    check((cyc - sb[0].t0) == sb[0].lat, "latency", cyc - sb[0].t0, sb[0].lat);
                end
                if (out_ready && sb.size() != 0) begin
                    txn_t t;
                    t = sb.pop_front();
                    check(gt == (t.a > t.b), "gt", gt, (t.a > t.b));
                    check(lt == (t.a < t.b), "lt", lt, (t.a < t.b));
                    check(eq == (t.a == t.b), "eq", eq, (t.a == t.b));
                end
                held     = !out_ready;
                held_res = {gt, lt, eq};
            end else begin
                check({gt, lt, eq} == 3'b000, "flags_idle", {gt, lt, eq}, 0);
                held = 1'b0;
            end
            if (in_valid && in_ready) begin
                txn_t n;
                n.a   = a_in;
                n.b   = b_in;
                n.t0  = cyc + 1;
                n.lat = model_lat(a_in, b_in);
                if (b2b_mode && prev_acc_b2b)
                    check((n.t0 - prev_t0) == prev_lat + 2, "throughput", n.t0 - prev_t0, prev_lat + 2);
                prev_t0      = n.t0;
                prev_lat     = n.lat;
                prev_acc_b2b = b2b_mode;
                sb.push_back(n);
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        n        = 0;
        a_in     = x;
        b_in     = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check(1'b0, "accept_timeout", n, 300);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) check(1'b0, "valid_timeout", n, 300);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check(sb.size() == 0, "drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        #12;
        check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
        check({out_valid, gt, lt, eq} == 4'b0000, "reset_outputs", {out_valid, gt, lt, eq}, 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'hA5A5, 16'hA5A5); in_valid = 1'b0; drain();
        send(16'hF000, 16'h0FFF); in_valid = 1'b0; drain();
        send(16'h1234, 16'h1235); in_valid = 1'b0; drain();
        send(16'h1300, 16'h12FF); in_valid = 1'b0; drain();

        // Back-pressure with a competing producer request held high.
        out_ready = 1'b0;
        send(16'h1300, 16'h12FF);
        a_in = 16'hBEEF;
        b_in = 16'h1234;
        wait_valid();
        repeat (5) @(negedge clk);
        check(sb.size() == 1, "no_accept_while_busy", sb.size(), 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check(in_ready == 1'b1, "idle_after_release", in_ready, 1);
        check(out_valid == 1'b0, "valid_drop_after_release", out_valid, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset during CMP, one edge after accept.
        send(16'h1234, 16'h1235);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(in_ready == 1'b1, "rst_cmp_in_ready", in_ready, 1);
        check({out_valid, gt, lt, eq} == 4'b0000, "rst_cmp_outputs", {out_valid, gt, lt, eq}, 0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Reset while a result is being held in DONE.
        out_ready = 1'b0;
        send(16'h0005, 16'h0003);
        in_valid = 1'b0;
        wait_valid();
        #1 rst_n = 1'b0;
        #1;
        check(in_ready == 1'b1, "rst_done_in_ready", in_ready, 1);
        check({out_valid, gt, lt, eq} == 4'b0000, "rst_done_outputs", {out_valid, gt, lt, eq}, 0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0001, 16'h0000); in_valid = 1'b0; drain();

        // Back-to-back random traffic.
        b2b_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            int           sel;
            x   = W'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      y = x;
            else if (sel == 1) y = x ^ (W'(1) << $urandom_range(0, W - 1));
            else               y = W'($urandom);
            send(x, y);
        end
        in_valid = 1'b0;
        b2b_mode = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
